// File: rtl/pad_poll_pkg.sv
// Shared constants for the game-pad poll sequencer: register offsets,
// FSM state encodings, configuration reset values and status limits.
package pad_poll_pkg;

   localparam logic [2:0] OFF_CTRL     = 3'd0;
   localparam logic [2:0] OFF_HALF     = 3'd1;
   localparam logic [2:0] OFF_INTERVAL = 3'd2;
   localparam logic [2:0] OFF_STATUS   = 3'd3;
   localparam logic [2:0] OFF_DATA     = 3'd4;

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_LATCH = 3'd1;
   localparam logic [2:0] ST_GAP   = 3'd2;
   localparam logic [2:0] ST_HIGH  = 3'd3;
   localparam logic [2:0] ST_LOW   = 3'd4;
   localparam logic [2:0] ST_DONE  = 3'd5;

   localparam int HALF_RESET = 600;
   localparam int INTV_RESET = 1666666;

   localparam logic [7:0] OVERRUN_MAX = 8'd255;

endpackage

// File: rtl/pad_poll_timebase.sv
// Half-bit prescaler (restartable at poll start) and the free-running poll
// interval counter, which is held clear while polling is disabled.
module pad_poll_timebase #(
   parameter int HALF_W = 16,
   parameter int INTV_W = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic              run,
   input  logic [HALF_W-1:0] half_period,
   input  logic              enable,
   input  logic [INTV_W-1:0] interval,
   output logic              half_tick,
   output logic              intv_tick
);

   logic [HALF_W-1:0] half_cnt;
   logic [INTV_W-1:0] intv_cnt;
   logic [INTV_W-1:0] intv_sh;

   assign half_tick = run & ~restart & (half_cnt == half_period - HALF_W'(1));
   assign intv_tick = enable & (intv_cnt == intv_sh - INTV_W'(1));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         half_cnt <= '0;
      end else if (restart || half_tick || !run) begin
         half_cnt <= '0;
      end else begin
         half_cnt <= half_cnt + HALF_W'(1);
      end
   end

   // The interval shadow only reloads on a tick or while disabled, so a new
   // INTERVAL value never disturbs a period already in progress.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         intv_cnt <= '0;
         intv_sh  <= interval;
      end else if (!enable || intv_tick) begin
         intv_cnt <= '0;
         intv_sh  <= interval;
      end else begin
         intv_cnt <= intv_cnt + INTV_W'(1);
      end
   end

endmodule

// File: rtl/pad_poll_sequencer.sv
// APB3 slave that polls a serial game pad: drives latch/sclk, shifts in the
// active-low button bits and publishes each frame with a ready strobe.
module pad_poll_sequencer
   import pad_poll_pkg::*;
#(
   parameter int NBITS  = 7,
   parameter int HALF_W = 16,
   parameter int INTV_W = 24
) (
   input  logic             PCLK,
   input  logic             PRESERN,
   input  logic             PSEL,
   input  logic             PENABLE,
   input  logic             PWRITE,
   input  logic [31:0]      PADDR,
   input  logic [31:0]      PWDATA,
   output logic             PREADY,
   output logic             PSLVERR,
   output logic [31:0]      PRDATA,
   input  logic             data,
   output logic             latch,
   output logic             sclk,
   output logic [NBITS-1:0] buttonData,
   output logic             ready
);

   localparam int BW = $clog2(NBITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(NBITS - 1);

   logic [2:0]        reg_idx;
   logic              apb_wr, apb_rd_access, apb_rd_setup;
   logic              enable;
   logic [HALF_W-1:0] half_reg, half_eff, half_sh;
   logic [INTV_W-1:0] intv_reg, intv_eff;
   logic [7:0]        overrun;
   logic              new_flag;
   logic [2:0]        state;
   logic              latch_half;
   logic [BW-1:0]     bit_idx;
   logic [NBITS-1:0]  shreg, sample_word;
   logic              half_tick, intv_tick, busy, start_wr, accept;
   logic [31:0]       rd_mux;
   logic              unused_apb;

   assign PREADY        = 1'b1;
   assign PSLVERR       = 1'b0;
   assign reg_idx       = PADDR[4:2];
   assign apb_wr        = PSEL & PENABLE & PWRITE;
   assign apb_rd_access = PSEL & PENABLE & ~PWRITE;
   assign apb_rd_setup  = PSEL & ~PENABLE & ~PWRITE;
   assign unused_apb    = ^{PADDR[31:5], PADDR[1:0], PWDATA};

   assign half_eff = (half_reg == '0) ? HALF_W'(1) : half_reg;
   assign intv_eff = (intv_reg == '0) ? INTV_W'(1) : intv_reg;
   assign busy     = (state != ST_IDLE);
   assign start_wr = apb_wr & (reg_idx == OFF_CTRL) & PWDATA[1];
   assign accept   = ~busy & (start_wr | intv_tick);

   pad_poll_timebase #(
      .HALF_W(HALF_W),
      .INTV_W(INTV_W)
   ) u_timebase (
      .clk        (PCLK),
      .rst_n      (PRESERN),
      .restart    (accept),
      .run        (busy),
      .half_period(half_sh),
      .enable     (enable),
      .interval   (intv_eff),
      .half_tick  (half_tick),
      .intv_tick  (intv_tick)
   );

   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         enable   <= 1'b0;
         half_reg <= HALF_W'(HALF_RESET);
         intv_reg <= INTV_W'(INTV_RESET);
      end else if (apb_wr) begin
         case (reg_idx)
            OFF_CTRL:     enable   <= PWDATA[0];
            OFF_HALF:     half_reg <= PWDATA[HALF_W-1:0];
            OFF_INTERVAL: intv_reg <= PWDATA[INTV_W-1:0];
            default:      ;
         endcase
      end
   end

   // new is set on leaving DONE so a DATA read landing in DONE cannot clear it.
   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         overrun  <= '0;
         new_flag <= 1'b0;
      end else begin
         if (apb_wr && reg_idx == OFF_STATUS)
            overrun <= '0;
         else if (busy && intv_tick && overrun != OVERRUN_MAX)
            overrun <= overrun + 8'd1;
         if (state == ST_DONE)
            new_flag <= 1'b1;
         else if (apb_rd_access && reg_idx == OFF_DATA)
            new_flag <= 1'b0;
      end
   end

   always_comb begin
      rd_mux = '0;
      case (reg_idx)
         OFF_CTRL:     rd_mux = {31'd0, enable};
         OFF_HALF:     rd_mux = 32'(half_reg);
         OFF_INTERVAL: rd_mux = 32'(intv_reg);
         OFF_STATUS:   rd_mux = {16'd0, overrun, 6'd0, new_flag, busy};
         OFF_DATA:     rd_mux = 32'(buttonData);
         default:      rd_mux = '0;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESERN)
         PRDATA <= '0;
      else if (apb_rd_setup)
         PRDATA <= rd_mux;
   end

   always_comb begin
      sample_word          = shreg;
      sample_word[bit_idx] = data;
   end

   // latch and sclk are updated together with the state so they never glitch.
   always_ff @(posedge PCLK) begin
      if (!PRESERN) begin
         state      <= ST_IDLE;
         latch      <= 1'b0;
         sclk       <= 1'b0;
         ready      <= 1'b0;
         buttonData <= '0;
         shreg      <= '0;
         bit_idx    <= '0;
         latch_half <= 1'b0;
         half_sh    <= HALF_W'(1);
      end else begin
         ready <= 1'b0;
         case (state)
            ST_IDLE: if (accept) begin
               state      <= ST_LATCH;
               latch      <= 1'b1;
               latch_half <= 1'b0;
               bit_idx    <= '0;
               half_sh    <= half_eff;
            end
            ST_LATCH: if (half_tick) begin
               if (latch_half) begin
                  state <= ST_GAP;
                  latch <= 1'b0;
               end else begin
                  latch_half <= 1'b1;
               end
            end
            ST_GAP: if (half_tick) begin
               shreg   <= sample_word;
               bit_idx <= BW'(1);
               state   <= ST_HIGH;
               sclk    <= 1'b1;
            end
            ST_HIGH: if (half_tick) begin
               state <= ST_LOW;
               sclk  <= 1'b0;
            end
            ST_LOW: if (half_tick) begin
               shreg <= sample_word;
               if (bit_idx == LAST_BIT) begin
                  state      <= ST_DONE;
                  buttonData <= ~sample_word;
                  ready      <= 1'b1;
               end else begin
                  bit_idx <= bit_idx + BW'(1);
                  state   <= ST_HIGH;
                  sclk    <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_pad_poll_sequencer.sv
// Randomised bench for pad_poll_sequencer: pin timing and frame contents are
// predicted from the poll-timing formulas, register contents from the map.
module tb_pad_poll_sequencer;

   localparam int NB = 7;
   localparam logic [31:0] A_CTRL = 32'h00, A_HALF = 32'h04, A_INTV = 32'h08;
   localparam logic [31:0] A_STAT = 32'h0C, A_DATA = 32'h10, A_UNMAP = 32'h18;
   localparam int NEVER = 1000000;

   logic          PCLK, PRESERN, PSEL, PENABLE, PWRITE;
   logic [31:0]   PADDR, PWDATA, PRDATA;
   logic          PREADY, PSLVERR;
   logic          data, latch, sclk, ready;
   logic [NB-1:0] buttonData;

   int            check_count = 0;
   int            fail_count  = 0;
   logic [NB-1:0] model_bits;
   logic [NB-1:0] model_buttons;
   logic [31:0]   rd;

   pad_poll_sequencer #(.NBITS(NB), .HALF_W(16), .INTV_W(24)) dut (
      .PCLK(PCLK), .PRESERN(PRESERN), .PSEL(PSEL), .PENABLE(PENABLE),
      .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY),
      .PSLVERR(PSLVERR), .PRDATA(PRDATA), .data(data), .latch(latch),
      .sclk(sclk), .buttonData(buttonData), .ready(ready)
   );

   initial begin
      PCLK = 1'b0;
      forever #5 PCLK = ~PCLK;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      check_count++;
      if (observed !== expected) begin
         fail_count++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
      end
   endtask

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic step_n(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic apb_write(input logic [31:0] addr, input logic [31:0] wdata);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = addr; PWDATA = wdata;
      step();
      PENABLE = 1'b1;
      step();
      PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
   endtask

   task automatic apb_read(input logic [31:0] addr, output logic [31:0] rdata);
      PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = addr;
      step();
      PENABLE = 1'b1;
      rdata = PRDATA;
      step();
      PSEL = 1'b0; PENABLE = 1'b0;
   endtask

   function automatic int poll_len(input int h);
      return 3 * h + 2 * h * (NB - 1);
   endfunction

   // Expected {latch, sclk, ready} at cycle n of a poll with half period h.
   function automatic logic [2:0] exp_pins(input int n, input int h);
      logic l, s, r;
      l = (n >= 0) && (n < 2 * h);
      s = (n >= 3 * h) && (n < poll_len(h)) && (((n - 3 * h) % (2 * h)) < h);
      r = (n == poll_len(h));
      return {l, s, r};
   endfunction

   function automatic int sample_index(input int n, input int h);
      int m;
      m = n + 1 - 3 * h;
      if (m < 0 || (m % (2 * h)) != 0 || (m / (2 * h)) >= NB) return -1;
      return m / (2 * h);
   endfunction

   function automatic int count_overruns(input int last_tick, input int len);
      int busy_end, cnt;
      busy_end = -1;
      cnt = 0;
      for (int t = 9; t <= last_tick; t += 10) begin
         if (t <= busy_end) cnt++;
         else busy_end = t + 1 + len;
      end
      return cnt;
   endfunction

   // Watches ncyc cycles starting at the current one; polls start at
   // first_start and repeat every period cycles.
   task automatic watch(input int ncyc, input int hw, input int period, input int first_start,
                        input logic [NB-1:0] pattern, input bit use_pattern, input bit done_read);
      int h, len, rel, pr, k;
      h   = (hw == 0) ? 1 : hw;
      len = poll_len(h);
      for (int c = 0; c < ncyc; c++) begin
         rel = c - first_start;
         pr  = (rel >= 0) ? (rel % period) : -1;
         checkOutput("pins", 32'(exp_pins(pr, h)), 32'({latch, sclk, ready}));
         if (pr == len) begin
            if (done_read && rel == len)
               checkOutput("done_read_old", PRDATA, 32'(model_buttons));
            model_buttons = ~model_bits;
            checkOutput("button_data", 32'(buttonData), 32'(model_buttons));
         end
         data = 1'($urandom_range(0, 1));
         k = (pr >= 0) ? sample_index(pr, h) : -1;
         if (k >= 0) begin
            if (use_pattern) data = pattern[k];
            model_bits[k] = data;
         end
         if (done_read && rel == len - 1) begin
            PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = A_DATA;
         end
         if (done_read && rel == len) PENABLE = 1'b1;
         step();
         if (done_read && rel == len) begin
            PSEL = 1'b0; PENABLE = 1'b0;
         end
      end
   endtask

   task automatic one_poll(input int hw, input logic [NB-1:0] pattern, input bit use_pattern, input bit done_read);
      int h;
      h = (hw == 0) ? 1 : hw;
      apb_write(A_HALF, 32'(hw));
      apb_write(A_CTRL, 32'h2);
      watch(poll_len(h) + 3, hw, NEVER, 0, pattern, use_pattern, done_read);
   endtask

   task automatic applyStimulus(input int n_polls);
      for (int i = 0; i < n_polls; i++) begin
         one_poll($urandom_range(0, 4), '0, 1'b0, 1'b0);
         apb_read(A_DATA, rd);
         checkOutput("rand_data_reg", rd, 32'(model_buttons));
      end
   endtask

   initial begin
      int c1, c2, exp_ovr;
      PRESERN = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
      PADDR = '0; PWDATA = '0; data = 1'b1;
      model_bits = '0; model_buttons = '0;

      step_n(3);
      checkOutput("reset_pins", 32'({latch, sclk, ready}), 32'h0);
      checkOutput("reset_buttons", 32'(buttonData), 32'h0);
      checkOutput("reset_prdata", PRDATA, 32'h0);
      PRESERN = 1'b1;
      step();
      apb_read(A_CTRL, rd); checkOutput("reset_ctrl", rd, 32'h0);
      apb_read(A_HALF, rd); checkOutput("reset_half", rd, 32'd600);
      apb_read(A_INTV, rd); checkOutput("reset_interval", rd, 32'd1666666);
      apb_read(A_STAT, rd); checkOutput("reset_status", rd, 32'h0);

      $display("[TB] directed poll, HALF=1");
      one_poll(1, 7'b1110110, 1'b1, 1'b0);
      checkOutput("directed_buttons", 32'(buttonData), 32'h09);
      apb_read(A_STAT, rd); checkOutput("status_new_set", rd, 32'h2);
      apb_read(A_DATA, rd); checkOutput("data_reg", rd, 32'h09);
      apb_read(A_STAT, rd); checkOutput("status_new_clear", rd, 32'h0);

      $display("[TB] HALF=0 poll and random polls");
      one_poll(0, 7'($urandom), 1'b1, 1'b0);
      apb_read(A_HALF, rd); checkOutput("half_zero_readback", rd, 32'h0);
      applyStimulus(5);

      $display("[TB] DATA read in DONE cycle");
      one_poll(2, 7'($urandom), 1'b1, 1'b1);
      apb_read(A_STAT, rd); checkOutput("done_read_new_kept", rd, 32'h2);
      apb_read(A_DATA, rd); checkOutput("done_read_new_data", rd, 32'(model_buttons));
      apb_read(A_STAT, rd); checkOutput("done_read_new_clear", rd, 32'h0);

      $display("[TB] periodic polling");
      apb_write(A_HALF, 32'd3);
      apb_write(A_INTV, 32'd100);
      apb_write(A_CTRL, 32'h1);
      watch(360, 3, 100, 100, '0, 1'b0, 1'b0);
      apb_write(A_CTRL, 32'h0);
      apb_read(A_STAT, rd); checkOutput("periodic_status", rd, 32'h2);
      apb_read(A_DATA, rd); checkOutput("periodic_data", rd, 32'(model_buttons));

      $display("[TB] overrun counting");
      apb_write(A_HALF, 32'd1);
      apb_write(A_INTV, 32'd10);
      data = 1'b1;
      apb_write(A_CTRL, 32'h1);
      step_n(395);
      apb_write(A_CTRL, 32'h0);
      step_n(30);
      c1 = count_overruns(396, poll_len(1));
      apb_read(A_STAT, rd); checkOutput("overrun_count", 32'(rd[15:8]), 32'(c1));
      checkOutput("overrun_idle", 32'(rd[0]), 32'h0);
      apb_write(A_CTRL, 32'h1);
      step_n(5300);
      apb_write(A_CTRL, 32'h0);
      step_n(30);
      c2 = count_overruns(5301, poll_len(1));
      exp_ovr = (c1 + c2 > 255) ? 255 : c1 + c2;
      apb_read(A_STAT, rd); checkOutput("overrun_saturate", 32'(rd[15:8]), 32'(exp_ovr));
      apb_write(A_STAT, $urandom);
      apb_read(A_STAT, rd); checkOutput("overrun_cleared", 32'(rd[15:8]), 32'h0);
      model_buttons = '0;
      apb_read(A_DATA, rd); checkOutput("overrun_data", rd, 32'h0);

      $display("[TB] unmapped offset");
      apb_write(A_UNMAP, 32'hFFFF_FFFF);
      apb_read(A_UNMAP, rd); checkOutput("unmapped_read", rd, 32'h0);
      apb_read(A_CTRL, rd); checkOutput("unmapped_ctrl", rd, 32'h0);
      apb_read(A_HALF, rd); checkOutput("unmapped_half", rd, 32'h1);
      watch(20, 1, NEVER, NEVER, '0, 1'b0, 1'b0);

      $display("[TB] reset mid-poll");
      one_poll(1, 7'h00, 1'b1, 1'b0);
      checkOutput("pre_reset_buttons", 32'(buttonData), 32'h7F);
      apb_write(A_CTRL, 32'h2);
      watch(7, 1, NEVER, 0, 7'($urandom), 1'b1, 1'b0);
      PRESERN = 1'b0;
      step();
      checkOutput("midreset_pins", 32'({latch, sclk, ready}), 32'h0);
      checkOutput("midreset_buttons", 32'(buttonData), 32'h0);
      PRESERN = 1'b1;
      model_buttons = '0;
      watch(20, 1, NEVER, NEVER, '0, 1'b0, 1'b0);
      apb_read(A_STAT, rd); checkOutput("midreset_status", rd, 32'h0);
      apb_read(A_HALF, rd); checkOutput("midreset_half", rd, 32'd600);

      $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
      $finish;
   end

endmodule
